vec_register_file_lanes: RTL and testbench
==========================================

Name: vec_register_file_lanes

Overview:
Parametrised vector register file for the SIMD datapath, generalising the fixed 15x128-bit file to configurable lane count, lane width and depth. It adds per-lane write masking, a lane-0 broadcast write mode, and a sequential clear engine that initialises every register after reset or on request. It sits between decode (read ports) and writeback (write port).

Parameters:
LANES, 8, number of vector lanes
LANE_W, 16, bits per lane; vector width VW = LANES*LANE_W
NREGS, 16, number of vector registers; AW = $clog2(NREGS)
SP_IDX, 13, register loaded with SP_INIT during clear
SP_INIT, 'h2000, VW-bit initial value of register SP_IDX (zero-extended)

Ports:
clk  in  1  clock; all state updates on falling edge
rst  in  1  asynchronous reset, active-low
we3  in  1  write enable
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
ra3  in  AW  write address
wd3  in  VW  write data
we_mask  in  LANES  per-lane write enable; bit i covers wd3[i*LANE_W +: LANE_W]
bcast  in  1  1 = replicate wd3 lane 0 into every enabled lane
clr_req  in  1  request a full re-clear
rd1  out  VW  read data, port 1
rd2  out  VW  read data, port 2
busy  out  1  clear engine active
wr_dropped  out  1  one-cycle pulse: a requested write was discarded

Behaviour:
- Storage array is not reset directly; it is initialised only by the clear engine.
- FSM states: CLEAR, RUN. Counter idx is AW bits wide.
- rst low (async): state=CLEAR, idx=0, busy=1, wr_dropped=0, rd1=rd2=0.
- CLEAR: each falling edge writes rf[idx] = (idx==SP_IDX) ? SP_INIT : 0, then idx++. On the edge that writes idx==NREGS-1, go to RUN and deassert busy. Clear takes exactly NREGS falling edges.
- RUN, we3=1, clr_req=0: on the falling edge, for each lane i with we_mask[i]=1, rf[ra3] lane i = bcast ? wd3[LANE_W-1:0] : wd3 lane i. Lanes with we_mask[i]=0 keep their value. we_mask=0 is a legal no-op and does not set wr_dropped.
- If ra3 >= NREGS (NREGS not a power of 2), the write is ignored and wr_dropped pulses.
- RUN, clr_req=1: go to CLEAR with idx=0 and busy=1 on that edge. A concurrent we3 is discarded and wr_dropped pulses.
- CLEAR, we3=1: write discarded, wr_dropped pulses. clr_req during CLEAR is ignored; the clear does not restart.
- wr_dropped is registered on the falling edge. It is high for one clock period per dropped write and low otherwise.
- Reads are combinational: rd1 = rf[ra1], rd2 = rf[ra2]. While busy=1, or if the address is >= NREGS, the read returns 0.
- A falling-edge write is visible on rd1/rd2 during the second half of the same cycle (write-first-half / read-second-half pipeline contract). No separate bypass mux.
- rst low mid-clear: the engine restarts from idx=0. A full NREGS edges are needed after release.

Test Plan:
1. Release rst, hold all inputs 0 -> busy stays 1 for 16 falling edges, then 0. rd1 with ra1=13 reads 128'h2000. Every other register reads 0.
2. RUN, we3=1, ra3=3, wd3=128'h000C000F00050001000B00030008000A, we_mask=8'h0F, bcast=0 -> rf[3] = 128'h0000000000000000000B00030008000A, wr_dropped stays 0.
3. RUN, we3=1, ra3=5, wd3[15:0]=16'h1234 (upper lanes random), we_mask=8'hFF, bcast=1 -> rf[5] = 128'h12341234123412341234123412341234. Repeat with we_mask=8'h81 on a zeroed register -> 128'h12340000000000000000000000001234.
4. We3=1, ra3=2 during busy -> wr_dropped high for exactly one period and rf[2] stays 0 after clear. With ra1=ra2=2 while busy, rd1=rd2=0.
5. RUN, rf[13] overwritten with 128'hFF; assert clr_req and we3 (ra3=4) on the same edge -> wr_dropped pulses, busy high for 16 edges, then rf[13]=128'h2000 and rf[4]=0.
6. Assert rst low after idx reaches 7 -> rd outputs 0 and busy stays 1. After release, busy lasts exactly 16 more falling edges and the final contents match scenario 1.

Source files
------------

// File: rtl/vec_register_file_lanes.sv
// Multi-lane vector register file: two combinational read ports, one masked/broadcast
// write port, and a sequential clear engine that initialises every register after reset.
module vec_register_file_lanes #(
   parameter int                         LANES   = 8,
   parameter int                         LANE_W  = 16,
   parameter int                         NREGS   = 16,
   parameter int                         SP_IDX  = 13,
   parameter logic [LANES*LANE_W-1:0]    SP_INIT = 'h2000,
   localparam int                        VW      = LANES * LANE_W,
   localparam int                        AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we3,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   input  logic [AW-1:0]     ra3,
   input  logic [VW-1:0]     wd3,
   input  logic [LANES-1:0]  we_mask,
   input  logic              bcast,
   input  logic              clr_req,
   output logic [VW-1:0]     rd1,
   output logic [VW-1:0]     rd2,
   output logic              busy,
   output logic              wr_dropped
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             wr_dropped_q, wr_dropped_d;

   logic [VW-1:0]    rf_q [NREGS];

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [LANES-1:0] wr_lane_en;
   logic [VW-1:0]    wr_data;
   logic             ra3_ok;

   assign ra3_ok = (int'(ra3) < NREGS);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      wr_dropped_d = 1'b0;
      wr_en        = 1'b0;
      wr_addr      = idx_q;
      wr_lane_en   = '0;
      wr_data      = '0;
      case (state_q)
         CLEAR: begin
            wr_en      = 1'b1;
            wr_addr    = idx_q;
            wr_lane_en = '1;
            wr_data    = (int'(idx_q) == SP_IDX) ? SP_INIT : '0;
            idx_d      = idx_q + 1'b1;
            if (int'(idx_q) == NREGS - 1) begin
               state_d = RUN;
            end
            // Writeback cannot land while the array is being initialised.
            wr_dropped_d = we3;
         end
         RUN: begin
            if (clr_req) begin
               state_d      = CLEAR;
               idx_d        = '0;
               wr_dropped_d = we3;
            end else if (we3) begin
               if (ra3_ok) begin
                  wr_en      = 1'b1;
                  wr_addr    = ra3;
                  wr_lane_en = we_mask;
                  wr_data    = bcast ? {LANES{wd3[LANE_W-1:0]}} : wd3;
               end else begin
                  wr_dropped_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = CLEAR;
            idx_d   = '0;
         end
      endcase
   end

   // State advances on the falling edge so reads settle in the second half of the cycle.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= CLEAR;
         idx_q        <= '0;
         wr_dropped_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         wr_dropped_q <= wr_dropped_d;
      end
   end

   always_ff @(negedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_lane_en[i]) begin
               rf_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
         end
      end
   end

   assign busy       = (state_q == CLEAR);
   assign wr_dropped = wr_dropped_q;

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (!busy && (int'(ra1) < NREGS)) begin
         rd1 = rf_q[ra1];
      end
      if (!busy && (int'(ra2) < NREGS)) begin
         rd2 = rf_q[ra2];
      end
   end

endmodule

// File: tb/tb_vec_register_file_lanes.sv
// Directed bench for vec_register_file_lanes: clear sequencing, masked/broadcast writes,
// dropped-write pulses, clear requests and reset during clear.
module tb_vec_register_file_lanes;

   localparam int LANES  = 8;
   localparam int LANE_W = 16;
   localparam int NREGS  = 16;
   localparam int VW     = LANES * LANE_W;
   localparam int AW     = 4;

   logic              clk;
   logic              rst;
   logic              we3;
   logic [AW-1:0]     ra1, ra2, ra3;
   logic [VW-1:0]     wd3;
   logic [LANES-1:0]  we_mask;
   logic              bcast;
   logic              clr_req;
   logic [VW-1:0]     rd1, rd2;
   logic              busy;
   logic              wr_dropped;

   int cmp_cnt = 0;
   int err_cnt = 0;

   vec_register_file_lanes #(
      .LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS), .SP_IDX(13), .SP_INIT('h2000)
   ) dut (
      .clk(clk), .rst(rst), .we3(we3), .ra1(ra1), .ra2(ra2), .ra3(ra3), .wd3(wd3),
      .we_mask(we_mask), .bcast(bcast), .clr_req(clr_req), .rd1(rd1), .rd2(rd2),
      .busy(busy), .wr_dropped(wr_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one falling edge and settle just after it.
   task automatic edge1();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [VW-1:0] d,
                     input logic [LANES-1:0] m, input logic b);
      we3 = 1'b1; ra3 = a; wd3 = d; we_mask = m; bcast = b;
      edge1();
      we3 = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [VW-1:0] exp);
      ra1 = a; ra2 = a;
      #1;
      chk({tag, "_rd1"}, rd1, exp);
      chk({tag, "_rd2"}, rd2, exp);
   endtask

   // Counts falling edges until busy drops; expects exactly NREGS in total.
   task automatic count_clear(input string tag, input int start);
      int n;
      n = start;
      while (busy && n < 40) begin
         edge1();
         n++;
      end
      chk(tag, VW'(n), VW'(NREGS));
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NREGS; i++) begin
         ra1 = AW'(i);
         ra2 = AW'(NREGS - 1 - i);
         #1;
         chk($sformatf("%s_rd1_r%0d", tag, i), rd1, (i == 13) ? VW'('h2000) : '0);
         chk($sformatf("%s_rd2_r%0d", tag, NREGS - 1 - i), rd2,
             ((NREGS - 1 - i) == 13) ? VW'('h2000) : '0);
      end
      edge1();
   endtask

   initial begin
      rst = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; ra3 = '0; wd3 = '0;
      we_mask = '0; bcast = 1'b0; clr_req = 1'b0;

      // Reset state
      edge1();
      edge1();
      ra1 = 4'd13; ra2 = 4'd0;
      #1;
      chk("rst_busy", VW'(busy), VW'(1));
      chk("rst_wr_dropped", VW'(wr_dropped), VW'(0));
      chk("rst_rd1", rd1, '0);
      chk("rst_rd2", rd2, '0);
      edge1();

      // Initial clear after reset release
      rst = 1'b1;
      count_clear("clear_len_init", 0);
      check_all("init");

      // Masked write, lower four lanes only
      wr(4'd3, 128'h000C000F00050001000B00030008000A, 8'h0F, 1'b0);
      chk("mask_wr_dropped", VW'(wr_dropped), VW'(0));
      rd_chk("mask_wr", 4'd3, 128'h0000000000000000000B00030008000A);
      edge1();

      // Empty mask is a no-op, not a drop
      wr(4'd3, '1, 8'h00, 1'b0);
      chk("nomask_wr_dropped", VW'(wr_dropped), VW'(0));
      rd_chk("nomask", 4'd3, 128'h0000000000000000000B00030008000A);
      edge1();

      // Broadcast lane 0 into all lanes, then into lanes 7 and 0 only
      wr(4'd5, 128'hDEADBEEFCAFEF00D0123456789AB1234, 8'hFF, 1'b1);
      rd_chk("bcast_all", 4'd5, 128'h12341234123412341234123412341234);
      edge1();
      wr(4'd6, 128'hDEADBEEFCAFEF00D0123456789AB1234, 8'h81, 1'b1);
      rd_chk("bcast_81", 4'd6, 128'h12340000000000000000000000001234);
      edge1();

      // Clear request with a concurrent write
      wr(4'd13, 128'hFF, 8'hFF, 1'b0);
      rd_chk("sp_overwrite", 4'd13, 128'hFF);
      edge1();
      wr(4'd4, {8{16'h5555}}, 8'hFF, 1'b0);
      rd_chk("r4_set", 4'd4, {8{16'h5555}});
      edge1();
      clr_req = 1'b1; we3 = 1'b1; ra3 = 4'd4; wd3 = '1; we_mask = 8'hFF; ra1 = 4'd13;
      edge1();
      chk("clr_wr_dropped", VW'(wr_dropped), VW'(1));
      chk("clr_busy", VW'(busy), VW'(1));
      chk("clr_rd1_busy", rd1, '0);

      // Write during clear is dropped; reads return zero while busy
      clr_req = 1'b0; we3 = 1'b1; ra3 = 4'd2; wd3 = '1; ra1 = 4'd2; ra2 = 4'd2;
      edge1();
      chk("busy_wr_dropped", VW'(wr_dropped), VW'(1));
      chk("busy_rd1", rd1, '0);
      chk("busy_rd2", rd2, '0);
      // Pulse ends after one period; clr_req during clear does not restart it
      we3 = 1'b0; clr_req = 1'b1;
      edge1();
      chk("busy_wr_dropped_end", VW'(wr_dropped), VW'(0));
      clr_req = 1'b0;
      count_clear("clear_len_req", 2);
      rd_chk("after_clr_r13", 4'd13, 128'h2000);
      rd_chk("after_clr_r4", 4'd4, '0);
      rd_chk("after_clr_r2", 4'd2, '0);
      rd_chk("after_clr_r3", 4'd3, '0);
      edge1();

      // Reset while the clear engine is mid-way through
      wr(4'd12, '1, 8'hFF, 1'b0);
      rd_chk("r12_set", 4'd12, '1);
      edge1();
      clr_req = 1'b1;
      edge1();
      clr_req = 1'b0;
      for (int k = 0; k < 6; k++) edge1();
      we3 = 1'b1; ra3 = 4'd1;
      edge1();
      we3 = 1'b0;
      chk("mid_clear_drop", VW'(wr_dropped), VW'(1));
      rst = 1'b0;
      ra1 = 4'd12; ra2 = 4'd13;
      #1;
      chk("midrst_busy", VW'(busy), VW'(1));
      chk("midrst_wr_dropped", VW'(wr_dropped), VW'(0));
      chk("midrst_rd1", rd1, '0);
      chk("midrst_rd2", rd2, '0);
      edge1();
      edge1();
      rst = 1'b1;
      count_clear("clear_len_rst", 0);
      check_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
